// File: rtl/store_drain_ctrl.sv
// Store-buffer drain sequencer: serialises fences and AMOs against
// committed stores, owns the D$ store-port hand-off and a drain watchdog.
module store_drain_ctrl #(
   parameter int unsigned DRAIN_TIMEOUT = 1024
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic flush_i,
   input  logic fence_req_i,
   output logic fence_done_o,
   input  logic amo_req_i,
   output logic amo_gnt_o,
   input  logic amo_done_i,
   input  logic no_st_pending_i,
   input  logic store_buffer_empty_i,
   output logic stall_store_o,
   output logic stall_st_pending_o,
   output logic drain_timeout_o,
   output logic busy_o
);

   localparam int unsigned CW = $clog2(DRAIN_TIMEOUT + 2);
   localparam logic [CW-1:0] WD_TO  = CW'(DRAIN_TIMEOUT);
   localparam logic [CW-1:0] WD_SAT = CW'(DRAIN_TIMEOUT + 1);

   typedef enum logic [1:0] {
      IDLE,
      DRAIN_FENCE,
      DRAIN_AMO,
      AMO_ACTIVE
   } state_e;

   state_e        state_q;
   logic [CW-1:0] wd_cnt_q;
   logic          draining;
   logic          drain_ok;

   assign draining = (state_q == DRAIN_FENCE) ||
                     (state_q == DRAIN_AMO);
   assign drain_ok = (state_q == DRAIN_FENCE) ?
                     store_buffer_empty_i : no_st_pending_i;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= IDLE;
         wd_cnt_q <= '0;
      end else begin
         // Saturation past the threshold keeps the timeout a single pulse
         if (draining && (wd_cnt_q != WD_SAT))
            wd_cnt_q <= wd_cnt_q + 1'b1;
         case (state_q)
            IDLE: begin
               if (amo_req_i) begin
                  state_q  <= DRAIN_AMO;
                  wd_cnt_q <= '0;
               end else if (fence_req_i) begin
                  state_q  <= DRAIN_FENCE;
                  wd_cnt_q <= '0;
               end
            end
            DRAIN_FENCE: begin
               if (store_buffer_empty_i)
                  state_q <= IDLE;
            end
            DRAIN_AMO: begin
               if (flush_i)
                  state_q <= IDLE;
               else if (no_st_pending_i)
                  state_q <= AMO_ACTIVE;
            end
            AMO_ACTIVE: begin
               if (amo_done_i)
                  state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign fence_done_o       = (state_q == DRAIN_FENCE) &&
                               store_buffer_empty_i;
   assign amo_gnt_o          = (state_q == AMO_ACTIVE);
   assign stall_st_pending_o = (state_q == AMO_ACTIVE);
   assign stall_store_o      = (state_q != IDLE);
   assign busy_o             = (state_q != IDLE);
   assign drain_timeout_o    = draining && (wd_cnt_q == WD_TO) &&
                               !drain_ok;

endmodule

// File: tb/tb_store_drain_ctrl.sv
// Bench for store_drain_ctrl: directed scenarios with literal checks
// plus randomized traffic against a behavioural model.
module tb_store_drain_ctrl;

   localparam int DT = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic flush = 1'b0, fence_req = 1'b0, amo_req = 1'b0;
   logic amo_done = 1'b0, nsp = 1'b0, sbe = 1'b0;
   logic fence_done, amo_gnt, stall_store, stall_stp, wd_to, busy;

   int vectors = 0;
   int miscompares = 0;

   // model: 0 idle, 1 fence drain, 2 amo drain, 3 amo granted
   int m_mode = 0;
   int m_age  = 0;

   logic a_fd, a_gnt, a_to, a_busy, a_ss, a_ssp;

   always #5 clk = ~clk;

   store_drain_ctrl #(.DRAIN_TIMEOUT(DT)) dut (
      .clk_i               (clk),
      .rst_ni              (rst_n),
      .flush_i             (flush),
      .fence_req_i         (fence_req),
      .fence_done_o        (fence_done),
      .amo_req_i           (amo_req),
      .amo_gnt_o           (amo_gnt),
      .amo_done_i          (amo_done),
      .no_st_pending_i     (nsp),
      .store_buffer_empty_i(sbe),
      .stall_store_o       (stall_store),
      .stall_st_pending_o  (stall_stp),
      .drain_timeout_o     (wd_to),
      .busy_o              (busy)
   );

   task automatic chk(input string name, input logic act,
                      input logic exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   // One clock: drive inputs, compare against the model, advance both
   task automatic step(input logic f, input logic fr, input logic ar,
                       input logic ad, input logic ns, input logic sb);
      logic e_fd, e_gnt, e_to, e_busy, cond;
      logic [5:0] e, a;
      flush = f; fence_req = fr; amo_req = ar;
      amo_done = ad; nsp = ns; sbe = sb;
      #1;
      cond   = (m_mode == 1) ? sb : ns;
      e_busy = (m_mode != 0);
      e_gnt  = (m_mode == 3);
      e_fd   = (m_mode == 1) && sb;
      e_to   = (m_mode == 1 || m_mode == 2) && (m_age == DT) && !cond;
      e = {e_fd, e_gnt, e_to, e_busy, e_busy, e_gnt};
      a = {fence_done, amo_gnt, wd_to, busy, stall_store, stall_stp};
      a_fd = fence_done; a_gnt = amo_gnt; a_to = wd_to;
      a_busy = busy; a_ss = stall_store; a_ssp = stall_stp;
      vectors++;
      if (a !== e) begin
         miscompares++;
         $display("FAIL model t=%0t {fd,gnt,to,busy,ss,ssp} got %b expected %b",
                  $time, a, e);
      end
      @(posedge clk);
      case (m_mode)
         0: if (ar) begin m_mode = 2; m_age = 0; end
            else if (fr) begin m_mode = 1; m_age = 0; end
         1: if (sb) m_mode = 0; else m_age++;
         2: if (f) m_mode = 0;
            else if (ns) m_mode = 3;
            else m_age++;
         default: if (ad) m_mode = 0;
      endcase
      @(negedge clk);
   endtask

   task automatic idle_steps(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 1, 1);
   endtask

   initial begin
      int pulses;
      int pulse_cyc;
      logic fr_r, ar_r;
      @(negedge clk);
      chk("reset_busy", busy, 1'b0);
      chk("reset_gnt", amo_gnt, 1'b0);
      chk("reset_fd", fence_done, 1'b0);
      chk("reset_to", wd_to, 1'b0);
      rst_n = 1'b1;
      idle_steps(2);

      // fence drain: buffer busy cycles 0..5, empty at 6
      for (int c = 0; c <= 7; c++) begin
         step(0, c < 6, 0, 0, 1, c >= 6);
         if (c == 1) chk("fence_stall_c1", a_ss, 1'b1);
         if (c == 5) chk("fence_no_done_c5", a_fd, 1'b0);
         if (c == 6) chk("fence_done_c6", a_fd, 1'b1);
         if (c == 7) chk("fence_idle_c7", a_busy, 1'b0);
      end

      // AMO: stores pending until cycle 3, done at 8
      for (int c = 0; c <= 9; c++) begin
         step(0, 0, c < 4, c == 8, c >= 3, 1);
         if (c == 3) chk("amo_nognt_c3", a_gnt, 1'b0);
         if (c == 4) chk("amo_gnt_c4", a_gnt, 1'b1);
         if (c == 8) chk("amo_ssp_c8", a_ssp, 1'b1);
         if (c == 9) chk("amo_gnt_off_c9", a_gnt, 1'b0);
         if (c == 9) chk("amo_ssp_off_c9", a_ssp, 1'b0);
      end

      // simultaneous requests: AMO first, then fence
      for (int c = 0; c <= 5; c++) begin
         step(0, c < 4, c < 2, c == 2, 1, 1);
         if (c == 2) chk("sim_gnt_c2", a_gnt, 1'b1);
         if (c == 3) chk("sim_idle_c3", a_busy, 1'b0);
         if (c == 4) chk("sim_fd_c4", a_fd, 1'b1);
      end

      // flush in DRAIN_AMO beats no_st_pending
      for (int c = 0; c <= 4; c++) begin
         step(c == 1, 0, c < 2, 0, 1, 1);
         if (c >= 2) chk("flush_amo_nognt", a_gnt, 1'b0);
         if (c == 2) chk("flush_amo_idle", a_busy, 1'b0);
      end
      // flush in DRAIN_FENCE ignored
      for (int c = 0; c <= 3; c++) begin
         step(c == 1, c < 3, 0, 0, 1, c == 3);
         if (c == 2) chk("flush_fence_busy", a_busy, 1'b1);
         if (c == 3) chk("flush_fence_fd", a_fd, 1'b1);
      end
      idle_steps(1);

      // watchdog: buffer stuck 11 cycles, empty at 11
      pulses = 0; pulse_cyc = -1;
      for (int c = 0; c <= 12; c++) begin
         step(0, c < 11, 0, 0, 1, c >= 11);
         if (a_to) begin pulses++; pulse_cyc = c; end
         if (c == 11) chk("wd_fd_after", a_fd, 1'b1);
      end
      chk("wd_one_pulse", pulses == 1, 1'b1);
      chk("wd_pulse_c5", pulse_cyc == 5, 1'b1);

      // async reset while granted
      step(0, 0, 1, 0, 1, 1);
      step(0, 0, 1, 0, 1, 1);
      chk("pre_rst_gnt", amo_gnt, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_gnt", amo_gnt, 1'b0);
      chk("rst_stall", stall_store, 1'b0);
      chk("rst_busy", busy, 1'b0);
      m_mode = 0; m_age = 0;
      @(negedge clk);
      rst_n = 1'b1;
      idle_steps(1);
      chk("post_rst_idle", a_busy, 1'b0);

      // randomized traffic with sticky requests
      fr_r = 0; ar_r = 0;
      for (int i = 0; i < 3000; i++) begin
         if (fr_r) begin
            if (fence_done && $urandom_range(0, 3) != 0) fr_r = 0;
         end else fr_r = ($urandom_range(0, 7) == 0);
         if (ar_r) begin
            if (amo_gnt) ar_r = 0;
         end else ar_r = ($urandom_range(0, 9) == 0);
         step($urandom_range(0, 7) == 0, fr_r, ar_r,
              $urandom_range(0, 3) == 0,
              $urandom_range(0, 5) == 0,
              $urandom_range(0, 6) == 0);
         if (a_fd) fr_r = 0;
         if (a_gnt) ar_r = 0;
      end

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
